// File: rtl/alu_pipe.sv
// alu_pipe -- registered, handshaked 6502-style ALU.
//
// Purpose:
//   Takes one operation per accepted in_valid/in_ready handshake and presents
//   a registered result plus C/V/Z/N flags with out_valid/out_ready flow
//   control. Binary operations complete one cycle after accept. Decimal
//   ADC/SBC take one extra cycle in the BCD state. A new operation is accepted
//   in the same cycle that the consumer drains a held result, so one op per
//   cycle is sustained.
//
// Ports:
//   clk        system clock, all state on the rising edge
//   rst_n      synchronous active-low reset
//   in_valid   operation offered
//   in_ready   operation accepted when in_valid & in_ready
//   op         0 ADC, 1 AND, 2 ORA, 3 EOR, 4 ASL, 5 LSR, 6 ROL, 7 ROR,
//              8 SBC, 9 CMP, 10 BIT, 11 INC, 12 DEC, 13-15 PASS A
//   op_a       operand A (accumulator side)
//   op_b       operand B (memory side)
//   carry_in   C flag in
//   decimal    D flag, only affects ADC/SBC when DECIMAL_EN=1
//   out_valid  result/flags valid
//   out_ready  consumer takes the result when out_valid & out_ready
//   result     registered result
//   carry_out, overflow, zero, sign   registered C, V, Z, N flags
module alu_pipe #(
    parameter int WIDTH      = 8,
    parameter bit DECIMAL_EN = 1'b1
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [3:0]       op,
    input  logic [WIDTH-1:0] op_a,
    input  logic [WIDTH-1:0] op_b,
    input  logic             carry_in,
    input  logic             decimal,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] result,
    output logic             carry_out,
    output logic             overflow,
    output logic             zero,
    output logic             sign
);

    localparam int NIB = WIDTH / 4;

    localparam logic [3:0] OP_ADC = 4'd0;
    localparam logic [3:0] OP_AND = 4'd1;
    localparam logic [3:0] OP_ORA = 4'd2;
    localparam logic [3:0] OP_EOR = 4'd3;
    localparam logic [3:0] OP_ASL = 4'd4;
    localparam logic [3:0] OP_LSR = 4'd5;
    localparam logic [3:0] OP_ROL = 4'd6;
    localparam logic [3:0] OP_ROR = 4'd7;
    localparam logic [3:0] OP_SBC = 4'd8;
    localparam logic [3:0] OP_CMP = 4'd9;
    localparam logic [3:0] OP_BIT = 4'd10;
    localparam logic [3:0] OP_INC = 4'd11;
    localparam logic [3:0] OP_DEC = 4'd12;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_BCD  = 2'd1,
        ST_FULL = 2'd2
    } state_t;

    typedef struct packed {
        logic [WIDTH-1:0] r;
        logic             c;
        logic             v;
        logic             z;
        logic             n;
    } res_t;

    // Binary result and flags. vprev is the currently registered V so that
    // operations which leave V alone simply pass it through.
    function automatic res_t alu_bin(
        input logic [3:0]       f,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin,
        input logic             vprev
    );
        res_t             o;
        logic [WIDTH-1:0] bx;
        logic [WIDTH:0]   sum;
        logic             cin_eff;
        // SBC and CMP add the one's complement of b; CMP always forces carry.
        bx      = (f == OP_SBC || f == OP_CMP) ? ~b : b;
        cin_eff = (f == OP_CMP) ? 1'b1 : cin;
        sum     = {1'b0, a} + {1'b0, bx} + (WIDTH+1)'(cin_eff);
        o.r = a;
        o.c = cin;
        o.v = vprev;
        case (f)
            OP_ADC, OP_SBC: begin
                o.r = sum[WIDTH-1:0];
                o.c = sum[WIDTH];
                o.v = (a[WIDTH-1] == bx[WIDTH-1]) && (sum[WIDTH-1] != a[WIDTH-1]);
            end
            OP_AND: o.r = a & b;
            OP_ORA: o.r = a | b;
            OP_EOR: o.r = a ^ b;
            OP_ASL: begin
                o.r = {a[WIDTH-2:0], 1'b0};
                o.c = a[WIDTH-1];
            end
            OP_LSR: begin
                o.r = {1'b0, a[WIDTH-1:1]};
                o.c = a[0];
            end
            OP_ROL: begin
                o.r = {a[WIDTH-2:0], cin};
                o.c = a[WIDTH-1];
            end
            OP_ROR: begin
                o.r = {cin, a[WIDTH-1:1]};
                o.c = a[0];
            end
            OP_CMP: o.c = sum[WIDTH];
            OP_INC: o.r = a + WIDTH'(1);
            OP_DEC: o.r = a - WIDTH'(1);
            default: o.r = a;
        endcase
        o.z = (o.r == '0);
        o.n = o.r[WIDTH-1];
        // CMP reports the difference through Z/N while returning a unchanged.
        if (f == OP_CMP) begin
            o.z = (sum[WIDTH-1:0] == '0);
            o.n = sum[WIDTH-1];
        end
        if (f == OP_BIT) begin
            o.z = ((a & b) == '0);
            o.n = b[WIDTH-1];
            o.v = b[WIDTH-2];
        end
        return o;
    endfunction

    // Per-nibble decimal add/subtract, least significant digit first.
    // Returns {carry_flag, result}. Invalid BCD digits run through the same
    // single correction step, so results stay deterministic.
    function automatic logic [WIDTH:0] bcd_calc(
        input logic             sub,
        input logic [WIDTH-1:0] a,
        input logic [WIDTH-1:0] b,
        input logic             cin
    );
        logic [WIDTH-1:0] r;
        logic             cy;
        logic [5:0]       d;
        r  = '0;
        cy = sub ? ~cin : cin;   // carry for ADC, borrow for SBC
        for (int i = 0; i < NIB; i++) begin
            if (!sub) begin
                d = {2'b00, a[4*i +: 4]} + {2'b00, b[4*i +: 4]} + {5'b00000, cy};
                if (d > 6'd9) begin
                    d  = d - 6'd10;
                    cy = 1'b1;
                end else begin
                    cy = 1'b0;
                end
            end else begin
                // Six bits hold -16..15 in two's complement; bit 5 is the sign.
                d = {2'b00, a[4*i +: 4]} - {2'b00, b[4*i +: 4]} - {5'b00000, cy};
                if (d[5]) begin
                    d  = d + 6'd10;
                    cy = 1'b1;
                end else begin
                    cy = 1'b0;
                end
            end
            r[4*i +: 4] = d[3:0];
        end
        return {sub ? ~cy : cy, r};
    endfunction

    state_t           state_reg, state_next;
    res_t             out_reg;
    res_t             bin_res;
    res_t             bcd_res;
    res_t             bin_of_dec;
    logic [WIDTH:0]   dec_sum;
    logic [WIDTH-1:0] a_reg, b_reg;
    logic             cin_reg, sub_reg;
    logic             accept, go_bcd;
    logic             load_bin, load_bcd, latch_ops;

    assign in_ready  = rst_n && ((state_reg == ST_IDLE) || (state_reg == ST_FULL && out_ready));
    assign accept    = in_valid && in_ready;
    assign go_bcd    = DECIMAL_EN && decimal && (op == OP_ADC || op == OP_SBC);

    assign bin_res   = alu_bin(op, op_a, op_b, carry_in, out_reg.v);

    // Decimal path works from the latched operands. V still reflects the
    // binary sum/difference of those operands.
    assign dec_sum    = bcd_calc(sub_reg, a_reg, b_reg, cin_reg);
    assign bin_of_dec = alu_bin(sub_reg ? OP_SBC : OP_ADC, a_reg, b_reg, cin_reg, out_reg.v);

    always_comb begin
        bcd_res   = bin_of_dec;
        bcd_res.r = dec_sum[WIDTH-1:0];
        bcd_res.c = dec_sum[WIDTH];
        bcd_res.z = (dec_sum[WIDTH-1:0] == '0);
        bcd_res.n = dec_sum[WIDTH-1];
    end

    always_comb begin
        state_next = state_reg;
        load_bin   = 1'b0;
        load_bcd   = 1'b0;
        latch_ops  = 1'b0;
        case (state_reg)
            ST_IDLE, ST_FULL: begin
                if (accept) begin
                    if (go_bcd) begin
                        latch_ops  = 1'b1;
                        state_next = ST_BCD;
                    end else begin
                        load_bin   = 1'b1;
                        state_next = ST_FULL;
                    end
                end else if (state_reg == ST_FULL && out_ready) begin
                    state_next = ST_IDLE;
                end
            end
            ST_BCD: begin
                load_bcd   = 1'b1;
                state_next = ST_FULL;
            end
            default: state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_reg <= ST_IDLE;
            out_reg   <= '0;
            a_reg     <= '0;
            b_reg     <= '0;
            cin_reg   <= 1'b0;
            sub_reg   <= 1'b0;
        end else begin
            state_reg <= state_next;
            if (load_bin) begin
                out_reg <= bin_res;
            end else if (load_bcd) begin
                out_reg <= bcd_res;
            end
            if (latch_ops) begin
                a_reg   <= op_a;
                b_reg   <= op_b;
                cin_reg <= carry_in;
                sub_reg <= (op == OP_SBC);
            end
        end
    end

    assign out_valid = (state_reg == ST_FULL);
    assign result    = out_reg.r;
    assign carry_out = out_reg.c;
    assign overflow  = out_reg.v;
    assign zero      = out_reg.z;
    assign sign      = out_reg.n;

endmodule

// File: tb/tb_alu_pipe.sv
// tb_alu_pipe -- self-checking bench for alu_pipe (WIDTH=8).
//
// A behavioural model computes every accepted operation with plain integer
// arithmetic and queues the expected result with the cycle it must appear.
// One negedge monitor checks in_ready, out_valid timing and the output
// value against that queue on every cycle. Directed operations with
// hand-computed literals pin the model. A second instance with
// DECIMAL_EN=0 checks that the decimal input is ignored there.
module tb_alu_pipe;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] op;
    logic [7:0] op_a, op_b;
    logic       carry_in, decimal;
    logic       out_valid, out_ready;
    logic [7:0] result;
    logic       carry_out, overflow, zero, sign;

    logic       in_valid2, in_ready2, out_valid2;
    logic       out_ready2 = 1'b1;
    logic [7:0] result2;
    logic       carry2, ovf2, zero2, sign2;

    alu_pipe #(.WIDTH(8), .DECIMAL_EN(1'b1)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .op(op), .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .decimal(decimal),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .carry_out(carry_out), .overflow(overflow), .zero(zero), .sign(sign)
    );

    alu_pipe #(.WIDTH(8), .DECIMAL_EN(1'b0)) dut_nodec (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid2), .in_ready(in_ready2),
        .op(op), .op_a(op_a), .op_b(op_b), .carry_in(carry_in), .decimal(decimal),
        .out_valid(out_valid2), .out_ready(out_ready2), .result(result2),
        .carry_out(carry2), .overflow(ovf2), .zero(zero2), .sign(sign2)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_cmp = 0;
    int n_err = 0;
    int n_xfer = 0;

    task automatic check(input string nm, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h (cycle %0d)", nm, got, exp, cyc);
        end
    endtask

    // Reference model: {result[7:0], C, V, N, Z}.
    function automatic logic [11:0] model(input int o, input int a, input int b,
                                          input bit cin, input bit dec, input bit den,
                                          input bit vp);
        int r, s, sa, sb, d, cy, ad, bd;
        bit c, v, n, z;
        sa = (a >= 128) ? a - 256 : a;
        sb = (b >= 128) ? b - 256 : b;
        r = a; c = cin; v = vp;
        case (o)
            0: begin
                s = a + b + int'(cin); r = s % 256; c = (s > 255);
                v = (sa + sb + int'(cin) > 127) || (sa + sb + int'(cin) < -128);
            end
            1: r = a & b;
            2: r = a | b;
            3: r = a ^ b;
            4: begin r = (a * 2) % 256; c = (a >= 128); end
            5: begin r = a / 2; c = (a % 2 == 1); end
            6: begin r = (a * 2 + int'(cin)) % 256; c = (a >= 128); end
            7: begin r = a / 2 + int'(cin) * 128; c = (a % 2 == 1); end
            8: begin
                s = a + (255 - b) + int'(cin); r = s % 256; c = (s > 255);
                v = (sa - sb - 1 + int'(cin) > 127) || (sa - sb - 1 + int'(cin) < -128);
            end
            9: begin r = a; c = (a >= b); end
            11: r = (a + 1) % 256;
            12: r = (a + 255) % 256;
            default: r = a;
        endcase
        if (den && dec && (o == 0 || o == 8)) begin
            cy = (o == 0) ? int'(cin) : 1 - int'(cin);
            r = 0;
            for (int i = 0; i < 2; i++) begin
                ad = (a >> (4 * i)) & 15;
                bd = (b >> (4 * i)) & 15;
                if (o == 0) begin
                    d = ad + bd + cy;
                    if (d > 9) begin d = d - 10; cy = 1; end else cy = 0;
                end else begin
                    d = ad - bd - cy;
                    if (d < 0) begin d = d + 10; cy = 1; end else cy = 0;
                end
                r = r + ((d & 15) << (4 * i));
            end
            c = (o == 0) ? (cy == 1) : (cy == 0);
        end
        z = (r == 0);
        n = (r >= 128);
        if (o == 9) begin
            z = (a == b);
            n = (((a - b) & 255) >= 128);
        end
        if (o == 10) begin
            z = ((a & b) == 0);
            n = b[7];
            v = b[6];
        end
        return {r[7:0], c, v, n, z};
    endfunction

    typedef struct {
        logic [11:0] exp;
        int          due;
        int          op;
    } item_t;

    item_t q[$];
    item_t m_item;
    bit    mv = 1'b0;
    bit    m_want;

    // Compare process: every negedge, check handshake and output against the queue.
    always @(negedge clk) begin
        if (!rst_n) begin
            check("in_ready_in_reset", 32'(in_ready), 32'd0);
            q.delete();
            mv = 1'b0;
        end else begin
            m_want = (q.size() == 0) || (q[0].due <= cyc && out_ready);
            check("in_ready", 32'(in_ready), 32'(m_want));
            if (q.size() == 0) begin
                check("out_valid_idle", 32'(out_valid), 32'd0);
            end else begin
                check("out_valid_timing", 32'(out_valid), 32'(q[0].due <= cyc));
                if (out_valid) begin
                    check("out_value", 32'({result, carry_out, overflow, sign, zero}), 32'(q[0].exp));
                    if (out_ready) begin
                        n_xfer++;
                        $display("xfer %0d: op=%0d result=%02h C=%0d V=%0d N=%0d Z=%0d",
                                 n_xfer, q[0].op, result, carry_out, overflow, sign, zero);
                        void'(q.pop_front());
                    end
                end
            end
            if (in_valid && in_ready) begin
                m_item.exp = model(int'(op), int'(op_a), int'(op_b), carry_in, decimal, 1'b1, mv);
                mv         = m_item.exp[2];
                m_item.due = cyc + ((decimal && (op == 4'd0 || op == 4'd8)) ? 2 : 1);
                m_item.op  = int'(op);
                q.push_back(m_item);
            end
        end
    end

    // Wait (bounded) for the offered op to be accepted; returns just after the accept edge.
    task automatic wait_accept(input string nm);
        bit done;
        done = 1'b0;
        for (int k = 0; k < 20 && !done; k++) begin
            @(negedge clk);
            if (in_ready) done = 1'b1;
            @(posedge clk); #1;
        end
        if (!done) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_accept: in_ready stayed 0 for 20 cycles, required 1", nm);
        end
    endtask

    // Directed op with literal expectations; flags packed {C,V,N,Z}, fm masks unchecked flags.
    task automatic run_op(input string nm, input logic [3:0] o, input logic [7:0] a,
                          input logic [7:0] b, input logic cin, input logic dec,
                          input int lat, input logic [7:0] er,
                          input logic [3:0] ef, input logic [3:0] fm);
        bit got;
        op = o; op_a = a; op_b = b; carry_in = cin; decimal = dec;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        wait_accept(nm);
        in_valid = 1'b0;
        got = 1'b0;
        for (int k = 1; k <= 4 && !got; k++) begin
            @(negedge clk);
            if (lat == 2 && k == 1) check({nm, "_busy_ready"}, 32'(in_ready), 32'd0);
            if (out_valid) begin
                got = 1'b1;
                check({nm, "_latency"}, 32'(k), 32'(lat));
                check({nm, "_result"}, 32'(result), 32'(er));
                check({nm, "_flags"}, 32'({carry_out, overflow, sign, zero} & fm), 32'(ef & fm));
            end
        end
        if (!got) begin
            n_cmp++;
            n_err++;
            $display("FAIL %s_valid: out_valid stayed 0 for 4 cycles, required 1", nm);
        end
        @(posedge clk); #1;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_valid2 = 1'b0; out_ready = 1'b1;
        op = 4'd0; op_a = 8'h00; op_b = 8'h00; carry_in = 1'b0; decimal = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("reset_out_valid", 32'(out_valid), 32'd0);
        check("reset_outputs", 32'({result, carry_out, overflow, sign, zero}), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;

        // Directed operations, hand-computed values
        run_op("adc_50_50", 4'd0,  8'h50, 8'h50, 1'b0, 1'b0, 1, 8'hA0, 4'b0110, 4'b1111);
        run_op("sbc_00_01", 4'd8,  8'h00, 8'h01, 1'b1, 1'b0, 1, 8'hFF, 4'b0010, 4'b1111);
        run_op("cmp_40_40", 4'd9,  8'h40, 8'h40, 1'b0, 1'b0, 1, 8'h40, 4'b1001, 4'b1011);
        run_op("dadc_45_38", 4'd0, 8'h45, 8'h38, 1'b0, 1'b1, 2, 8'h83, 4'b0010, 4'b1111);
        run_op("dadc_99_01", 4'd0, 8'h99, 8'h01, 1'b0, 1'b1, 2, 8'h00, 4'b1001, 4'b1111);
        run_op("dsbc_10_01", 4'd8, 8'h10, 8'h01, 1'b1, 1'b1, 2, 8'h09, 4'b1000, 4'b1111);
        run_op("ror_01",    4'd7,  8'h01, 8'h00, 1'b1, 1'b0, 1, 8'h80, 4'b1010, 4'b1011);
        run_op("bit_0f_c0", 4'd10, 8'h0F, 8'hC0, 1'b0, 1'b0, 1, 8'h0F, 4'b0111, 4'b1111);

        // DECIMAL_EN=0: decimal input ignored, binary result in one cycle
        op = 4'd0; op_a = 8'h45; op_b = 8'h38; carry_in = 1'b0; decimal = 1'b1;
        in_valid = 1'b0; in_valid2 = 1'b1;
        @(negedge clk);
        check("nodec_ready", 32'(in_ready2), 32'd1);
        @(posedge clk); #1;
        in_valid2 = 1'b0;
        @(negedge clk);
        check("nodec_valid", 32'(out_valid2), 32'd1);
        check("nodec_result", 32'({result2, carry2}), 32'({8'h7D, 1'b0}));
        @(posedge clk); #1;
        decimal = 1'b0;

        // Backpressure: result held, in_ready low, then drain+accept together
        out_ready = 1'b0;
        op = 4'd0; op_a = 8'h12; op_b = 8'h34; carry_in = 1'b0; in_valid = 1'b1;
        wait_accept("bp_first");
        op = 4'd3; op_a = 8'hF0; op_b = 8'hFF;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_hold_ready", 32'(in_ready), 32'd0);
            check("bp_hold_result", 32'(result), 32'h46);
            @(posedge clk); #1;
        end
        out_ready = 1'b1;
        @(negedge clk);
        check("bp_release_ready", 32'(in_ready), 32'd1);
        check("bp_release_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(negedge clk);
        check("bp_next_valid", 32'(out_valid), 32'd1);
        check("bp_next_result", 32'(result), 32'h0F);
        @(posedge clk); #1;

        // Ten back-to-back binary ops: accepted each cycle, done in 11 cycles
        out_ready = 1'b1;
        decimal   = 1'b0;
        for (int i = 0; i < 10; i++) begin
            op = 4'($urandom_range(0, 15)); op_a = 8'($urandom); op_b = 8'($urandom);
            carry_in = 1'($urandom_range(0, 1));
            in_valid = 1'b1;
            @(negedge clk);
            check("b2b_ready", 32'(in_ready), 32'd1);
            @(posedge clk); #1;
        end
        in_valid = 1'b0;
        @(negedge clk);
        check("b2b_last_valid", 32'(out_valid), 32'd1);
        @(posedge clk); #1;
        @(negedge clk);
        check("b2b_done", 32'(out_valid), 32'd0);
        @(posedge clk); #1;

        // Reset while a decimal op is in the BCD state
        op = 4'd0; op_a = 8'h27; op_b = 8'h15; carry_in = 1'b0; decimal = 1'b1;
        in_valid = 1'b1;
        wait_accept("rst_bcd");
        in_valid = 1'b0;
        rst_n = 1'b0;
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_bcd_valid", 32'(out_valid), 32'd0);
        check("rst_bcd_outputs", 32'({result, carry_out, overflow, sign, zero}), 32'd0);
        @(posedge clk); #1;
        run_op("after_rst_adc", 4'd0, 8'h01, 8'h02, 1'b0, 1'b0, 1, 8'h03, 4'b0000, 4'b1111);

        // Randomized traffic with random backpressure
        for (int i = 0; i < 1500; i++) begin
            in_valid  = ($urandom_range(0, 9) < 7);
            op        = 4'($urandom_range(0, 15));
            op_a      = 8'($urandom);
            op_b      = 8'($urandom);
            carry_in  = 1'($urandom_range(0, 1));
            decimal   = 1'($urandom_range(0, 1));
            out_ready = ($urandom_range(0, 9) < 7);
            @(posedge clk); #1;
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("final_drain", 32'(q.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
